// File: rtl/matrix_scan_driver_pkg.sv
// Shared types and constants for the 5x7 matrix scan driver.
// Pixel numbering is column-major: index = col*rows + row.
package matrix_pkg;
    localparam int MATRIX_ROWS = 7;
    localparam int MATRIX_COLS = 5;
    localparam int MATRIX_PIX  = MATRIX_ROWS * MATRIX_COLS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    function automatic int pix_idx(input int col, input int row,
                                   input int rows = MATRIX_ROWS);
        return col * rows + row;
    endfunction
endpackage

// File: rtl/matrix_scan_driver_if.sv
// Decoder-to-driver bundle: pixel map in, column/row drive out.
// blinkMask is present only when MATRIX_BLINK_EN is defined.
interface matrix_scan_driver_if
    import matrix_pkg::*;
#(
    parameter int COLUNE_SIZE   = MATRIX_ROWS,
    parameter int TOTAL_COLUNES = MATRIX_COLS,
    parameter int DATA_WIDTH    = MATRIX_PIX
);
    logic                     enable;
    logic [DATA_WIDTH-1:0]    mapIn;
`ifdef MATRIX_BLINK_EN
    logic [DATA_WIDTH-1:0]    blinkMask;
`endif
    logic [TOTAL_COLUNES-1:0] colOut;
    logic [COLUNE_SIZE-1:0]   rowOut;
    logic                     frameStart;

`ifdef MATRIX_BLINK_EN
    modport master (output enable, mapIn, blinkMask, input colOut, rowOut, frameStart);
    modport slave  (input enable, mapIn, blinkMask, output colOut, rowOut, frameStart);
`else
    modport master (output enable, mapIn, input colOut, rowOut, frameStart);
    modport slave  (input enable, mapIn, output colOut, rowOut, frameStart);
`endif
endinterface

// File: rtl/matrix_scan_driver_scan_prescaler.sv
// Loadable terminal-count counter: load restarts at 0 with a new terminal,
// clear zeroes the count, and counting stops at the terminal value.
module scan_prescaler #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_term,
    input  logic         i_en,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_term;

    assign o_tc = (r_cnt == r_term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_term <= '0;
        end else if (i_clr) begin
            r_cnt  <= '0;
        end else if (i_load) begin
            r_cnt  <= '0;
            r_term <= i_term;
        end else if (i_en && !o_tc) begin
            r_cnt  <= r_cnt + W'(1);
        end
    end
endmodule

// File: rtl/matrix_scan_driver.sv
// Column-multiplexed 5x7 LED scan driver with per-frame double buffering.
// Optional blink feature enabled by defining MATRIX_BLINK_EN.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int COLUNE_SIZE   = MATRIX_ROWS,
    parameter int TOTAL_COLUNES = MATRIX_COLS,
    parameter int DATA_WIDTH    = MATRIX_PIX,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYCLES  = 8,
    parameter int BLINK_FRAMES  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    matrix_scan_driver_if.slave  bus
);
    localparam int CW   = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
    localparam int MAXC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    scan_state_e              r_state, w_state_nxt;
    logic [CW-1:0]            r_col, w_col_nxt;
    logic [DATA_WIDTH-1:0]    r_frame;
    logic [DATA_WIDTH-1:0]    w_frame_eff;
    logic [TOTAL_COLUNES-1:0] r_colOut;
    logic [COLUNE_SIZE-1:0]   r_rowOut;
    logic                     r_frameStart;
    logic                     w_latch, w_load, w_clr, w_cnt_en, w_tc;
    logic [PW-1:0]            w_term;
    logic [TOTAL_COLUNES-1:0] w_onehot;
    logic [TOTAL_COLUNES-1:0][COLUNE_SIZE-1:0] w_cols;

    scan_prescaler #(.W(PW)) u_presc (
        .clk    (clk),
        .rst_n  (reset),
        .i_clr  (w_clr),
        .i_load (w_load),
        .i_term (w_term),
        .i_en   (w_cnt_en),
        .o_tc   (w_tc)
    );

    // enable low overrides every counter transition on the same edge
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        w_cnt_en    = 1'b0;
        w_term      = PW'(BLANK_CYCLES - 1);
        if (!bus.enable) begin
            w_state_nxt = ST_IDLE;
            w_col_nxt   = '0;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_BLANK;
                    w_col_nxt   = '0;
                    w_latch     = 1'b1;
                    w_load      = 1'b1;
                end
                ST_BLANK: begin
                    if (w_tc) begin
                        w_state_nxt = ST_DRIVE;
                        w_load      = 1'b1;
                        w_term      = PW'(SCAN_DIV - 1);
                    end else begin
                        w_cnt_en    = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (w_tc) begin
                        w_state_nxt = ST_BLANK;
                        w_load      = 1'b1;
                        if (r_col == CW'(TOTAL_COLUNES - 1)) begin
                            w_col_nxt = '0;
                            w_latch   = 1'b1;
                        end else begin
                            w_col_nxt = r_col + CW'(1);
                        end
                    end else begin
                        w_cnt_en    = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef MATRIX_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [FW-1:0]         r_fcnt;
    logic                  r_phase;

    // a latch out of IDLE is frame 0, so the blink cadence restarts there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask  <= '0;
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_latch) begin
            r_mask <= bus.blinkMask;
            if (r_state == ST_IDLE) begin
                r_fcnt  <= '0;
                r_phase <= 1'b0;
            end else if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                r_fcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_fcnt  <= r_fcnt + FW'(1);
            end
        end
    end

    assign w_frame_eff = r_frame | (r_mask & {DATA_WIDTH{r_phase}});
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    assign w_frame_eff = r_frame;
`endif

    for (genvar c = 0; c < TOTAL_COLUNES; c++) begin : g_col
        for (genvar r = 0; r < COLUNE_SIZE; r++) begin : g_row
            assign w_cols[c][r] = w_frame_eff[pix_idx(c, r, COLUNE_SIZE)];
        end
    end

    assign w_onehot = TOTAL_COLUNES'(1) << r_col;

    // outputs are computed from next state so they appear with the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_frame      <= '1;
            r_colOut     <= '0;
            r_rowOut     <= '1;
            r_frameStart <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_col        <= w_col_nxt;
            r_frameStart <= w_latch;
            if (w_latch)
                r_frame <= bus.mapIn;
            if (w_state_nxt == ST_DRIVE) begin
                r_colOut <= w_onehot;
                r_rowOut <= w_cols[r_col];
            end else begin
                r_colOut <= '0;
                r_rowOut <= '1;
            end
        end
    end

    assign bus.colOut     = r_colOut;
    assign bus.rowOut     = r_rowOut;
    assign bus.frameStart = r_frameStart;
endmodule

// File: doc/matrix_scan_driver.md
# matrix_scan_driver

Column-multiplexed scan driver for the 5×7 LED matrix. It sits directly downstream of the map decoder and takes its 35-bit active-low pixel map. It double-buffers one frame per scan so the picture never tears, and drives one column at a time with a blanking gap between columns to suppress ghosting. Pixel index is `column*7 + row`: column a=0 … e=4, row 1=0 … 7=6, and a map bit of 1 means the LED is off.

## Interface
- `COLUNE_SIZE`, default 7: rows per column.
- `TOTAL_COLUNES`, default 5: number of columns.
- `DATA_WIDTH`, default 35: must equal COLUNE_SIZE*TOTAL_COLUNES.
- `SCAN_DIV`, default 50000: DRIVE cycles per column, ≥1.
- `BLANK_CYCLES`, default 8: BLANK cycles per column, ≥1.
- `BLINK_FRAMES`, default 16: frames per blink half-period, ≥1. Used only with MATRIX_BLINK_EN.
- `clk`, input, 1: the single system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: scan enable. Low blanks the matrix.
- `mapIn`, input, DATA_WIDTH: pixel map from the decoder, active-low pixels.
- `blinkMask`, input, DATA_WIDTH: set bits blink. Present only with MATRIX_BLINK_EN.
- `colOut`, output, TOTAL_COLUNES: one-hot column select, active-high.
- `rowOut`, output, COLUNE_SIZE: row drive, active-low (bit r = row r+1).
- `frameStart`, output, 1: one-cycle pulse when a new frame is latched.

## Operation
- FSM states: IDLE, BLANK, DRIVE. Internal registers: column index `col` (0..4), prescaler `cnt`, frame shadow `frame`.
- Reset values:
  - State = IDLE; `col`=0; `cnt`=0; `frame` = all ones.
  - `colOut`=0; `rowOut` = all ones; `frameStart`=0; blink phase=0; frame counter=0.
- IDLE:
  - Outputs are off: `colOut`=0, `rowOut` all ones.
  - When `enable`=1, go to BLANK with `col`=0 and perform a frame latch.
- BLANK:
  - Outputs are off.
  - Run BLANK_CYCLES cycles, then go to DRIVE with `cnt`=0.
- DRIVE:
  - `colOut` = one-hot(`col`); `rowOut` = `frame[col*7 +: 7]`.
  - Run SCAN_DIV cycles, then go to BLANK.
  - On that transition, `col` increments. At `col`=4 it wraps to 0 and a frame latch occurs.
- Frame latch:
  - `frame` ← `mapIn` on the transition edge.
  - `frameStart`=1 for exactly the first BLANK cycle of column 0.
  - `mapIn` changes between latches have no visible effect.
- `enable` falling in any state: next cycle is IDLE, outputs are off, `col`/`cnt` are cleared. Re-enabling always restarts at column 0 with a fresh latch.
- `enable` has priority over all counter transitions on the same edge.
- Counters are sized `$clog2` of their maximum count. There is no overflow beyond the terminal count; terminal count is `SCAN_DIV-1` and `BLANK_CYCLES-1` respectively.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Column period = BLANK_CYCLES + SCAN_DIV cycles.
- Frame period = TOTAL_COLUNES × column period.
- Latency from `enable` rising to first lit column: 1 cycle to enter BLANK, plus BLANK_CYCLES cycles.
- `mapIn` must be stable on the latch edge. It is sampled only on that edge.
- Reset asserted mid-scan: outputs go off asynchronously and immediately. After release, operation restarts from IDLE.

## Configuration
- Macro `MATRIX_BLINK_EN`.
- Defined:
  - `blinkMask` exists and is latched alongside `frame`.
  - A frame counter increments on each `frameStart`. Every BLINK_FRAMES frames it toggles the blink phase; the phase starts at 0 after IDLE.
  - While phase=1, masked pixels are forced to 1 (off).
- Not defined: no `blinkMask` port and no blink logic. Behaviour is identical to the defined case with an all-zero mask.

## Structure
- Shared package `matrix_pkg` holds:
  - the state enum (IDLE/BLANK/DRIVE);
  - matrix dimension constants;
  - a pixel-index function `(col,row) → col*7+row`.
- Sub-module `scan_prescaler`: a loadable terminal-count counter with a clear input. It is instanced once and reloaded with SCAN_DIV or BLANK_CYCLES per state.

## Test plan
All scenarios use SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2.
- Reset while enabled mid-DRIVE → same cycle `colOut`=5'b00000, `rowOut`=7'h7F, `frameStart`=0.
- `mapIn` all ones except bits 0 (a1) and 13 (b7) cleared, `enable`=1:
  - column a DRIVE: `colOut`=5'b00001, `rowOut`=7'b1111110;
  - column b DRIVE: `colOut`=5'b00010, `rowOut`=7'b0111111;
  - c–e: `rowOut`=7'h7F.
- `mapIn` changed during column c DRIVE → columns c–e still show the old frame. The new frame appears on column a after the next `frameStart`.
- Free run for 100 cycles → `frameStart` pulses exactly every 25 cycles, once per pulse. Column order is a,b,c,d,e,a with one blank cycle between each.
- `enable` dropped in column d DRIVE → next cycle outputs are off. Re-enable → `frameStart` next cycle, column a lit 2 cycles after re-enable.
- With `MATRIX_BLINK_EN`, bit 0 of `blinkMask` set and a1 lit → a1 visible in frames 0–1, off in frames 2–3, visible in frames 4–5. All other pixels are unaffected.
